// File: rtl/motor_drive_pkg.sv
// Shared encodings and defaults for the two-wheel motor driver.
package motor_drive_pkg;
  localparam logic [1:0] CMD_PROCEED = 2'b00;
  localparam logic [1:0] CMD_LEFT    = 2'b01;
  localparam logic [1:0] CMD_RIGHT   = 2'b10;
  localparam logic [1:0] CMD_STOP    = 2'b11;

  localparam logic [1:0] MODE_FULL   = 2'b00;
  localparam logic [1:0] MODE_VEER   = 2'b01;
  localparam logic [1:0] MODE_NINETY = 2'b11;

  typedef logic [0:0] ch_state_t;
  localparam ch_state_t ST_RUN  = 1'b0;
  localparam ch_state_t ST_DEAD = 1'b1;

  localparam int DEF_PWM_PERIOD   = 1000;
  localparam int DEF_DUTY_FULL    = 1000;
  localparam int DEF_DUTY_VEER    = 500;
  localparam int DEF_DUTY_PIVOT   = 600;
  localparam int DEF_RAMP_STEP    = 100;
  localparam int DEF_DEAD_PERIODS = 2;
endpackage

// File: rtl/motor_channel.sv
// One wheel: RUN/DEAD polarity-flip FSM, boundary-only duty ramp, PWM compare.
module motor_channel
  import motor_drive_pkg::*;
#(
  parameter int PWM_PERIOD   = DEF_PWM_PERIOD,
  parameter int RAMP_STEP    = DEF_RAMP_STEP,
  parameter int DEAD_PERIODS = DEF_DEAD_PERIODS,
  localparam int DW          = $clog2(PWM_PERIOD + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          bnd_i,
  input  logic [DW-1:0] cnt_nxt_i,
  input  logic          tgt_pol_i,
  input  logic [DW-1:0] tgt_duty_i,
  output logic          pwm_o,
  output logic          dir_o,
  output logic          at_tgt_o
);
  localparam int DCW = $clog2(DEAD_PERIODS + 1);
  localparam logic [DW-1:0]  STEP   = DW'(RAMP_STEP);
  localparam logic [DCW-1:0] DEAD_N = DCW'(DEAD_PERIODS);

  ch_state_t      st_q, st_d;
  logic [DW-1:0]  duty_q, duty_d;
  logic [DCW-1:0] dead_q, dead_d, dead_inc;
  logic           dir_q, dir_d, pwm_q, pwm_d;

  assign dead_inc = dead_q + DCW'(1);

  always_comb begin
    st_d   = st_q;
    duty_d = duty_q;
    dead_d = dead_q;
    dir_d  = dir_q;
    if (bnd_i) begin
      if (st_q == ST_RUN) begin
        if (tgt_pol_i != dir_q) begin
          duty_d = '0;
          dead_d = '0;
          st_d   = ST_DEAD;
        end else if (duty_q < tgt_duty_i) begin
          duty_d = (tgt_duty_i - duty_q > STEP) ? duty_q + STEP : tgt_duty_i;
        end else begin
          duty_d = (duty_q - tgt_duty_i > STEP) ? duty_q - STEP : tgt_duty_i;
        end
      end else begin
        // Target changes here are ignored: DEAD always runs its full length.
        dead_d = dead_inc;
        if (dead_inc == DEAD_N) begin
          st_d   = ST_RUN;
          dir_d  = tgt_pol_i;
          duty_d = '0;
        end
      end
    end
    // Compare against next-cycle count so pwm_q lines up with the live count.
    pwm_d = (st_d == ST_RUN) && (cnt_nxt_i < duty_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= ST_RUN;
      duty_q <= '0;
      dead_q <= '0;
      dir_q  <= 1'b1;
      pwm_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      duty_q <= duty_d;
      dead_q <= dead_d;
      dir_q  <= dir_d;
      pwm_q  <= pwm_d;
    end
  end

  assign pwm_o    = pwm_q;
  assign dir_o    = dir_q;
  assign at_tgt_o = (st_q == ST_RUN) && (duty_q == tgt_duty_i);
endmodule

// File: rtl/motor_drive.sv
// Two-wheel PWM motor driver: command register, target decode, shared period counter.
module motor_drive
  import motor_drive_pkg::*;
#(
  parameter int PWM_PERIOD   = DEF_PWM_PERIOD,
  parameter int DUTY_FULL    = DEF_DUTY_FULL,
  parameter int DUTY_VEER    = DEF_DUTY_VEER,
  parameter int DUTY_PIVOT   = DEF_DUTY_PIVOT,
  parameter int RAMP_STEP    = DEF_RAMP_STEP,
  parameter int DEAD_PERIODS = DEF_DEAD_PERIODS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] dir,
  output logic       pwm_l,
  output logic       pwm_r,
  output logic       dir_l,
  output logic       dir_r,
  output logic       settled
);
  localparam int DW = $clog2(PWM_PERIOD + 1);
  localparam logic [DW-1:0] LAST    = DW'(PWM_PERIOD - 1);
  localparam logic [DW-1:0] D_FULL  = DW'(DUTY_FULL);
  localparam logic [DW-1:0] D_VEER  = DW'(DUTY_VEER);
  localparam logic [DW-1:0] D_PIVOT = DW'(DUTY_PIVOT);

  logic [3:0]    dir_q;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          bnd;
  logic          pol_l, pol_r, at_l, at_r, settled_q;
  logic [DW-1:0] duty_l, duty_r;

  assign bnd   = (cnt_q == LAST);
  assign cnt_d = bnd ? '0 : cnt_q + DW'(1);

  always_comb begin
    pol_l  = 1'b1;
    pol_r  = 1'b1;
    duty_l = D_FULL;
    duty_r = D_FULL;
    case (dir_q[3:2])
      CMD_LEFT: begin
        if (dir_q[1:0] == MODE_NINETY) begin
          pol_l  = 1'b0;
          duty_l = D_PIVOT;
          duty_r = D_PIVOT;
        end else begin
          duty_l = D_VEER;
        end
      end
      CMD_RIGHT: begin
        if (dir_q[1:0] == MODE_NINETY) begin
          pol_r  = 1'b0;
          duty_l = D_PIVOT;
          duty_r = D_PIVOT;
        end else begin
          duty_r = D_VEER;
        end
      end
      CMD_STOP: begin
        // Stop keeps each wheel's present polarity so it never triggers a flip.
        pol_l  = dir_l;
        pol_r  = dir_r;
        duty_l = '0;
        duty_r = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q     <= 4'b1111;
      cnt_q     <= '0;
      settled_q <= 1'b0;
    end else begin
      dir_q     <= dir;
      cnt_q     <= cnt_d;
      settled_q <= at_l & at_r;
    end
  end

  motor_channel #(
    .PWM_PERIOD(PWM_PERIOD), .RAMP_STEP(RAMP_STEP), .DEAD_PERIODS(DEAD_PERIODS)
  ) u_left (
    .clk(clk), .rst(rst), .bnd_i(bnd), .cnt_nxt_i(cnt_d),
    .tgt_pol_i(pol_l), .tgt_duty_i(duty_l),
    .pwm_o(pwm_l), .dir_o(dir_l), .at_tgt_o(at_l)
  );

  motor_channel #(
    .PWM_PERIOD(PWM_PERIOD), .RAMP_STEP(RAMP_STEP), .DEAD_PERIODS(DEAD_PERIODS)
  ) u_right (
    .clk(clk), .rst(rst), .bnd_i(bnd), .cnt_nxt_i(cnt_d),
    .tgt_pol_i(pol_r), .tgt_duty_i(duty_r),
    .pwm_o(pwm_r), .dir_o(dir_r), .at_tgt_o(at_r)
  );

  assign settled = settled_q;
endmodule

// File: tb/tb_motor_drive.sv
// Directed bench for motor_drive: measures PWM high time per period against hand values.
module tb_motor_drive;
  localparam int PER = 1000;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] dir;
  logic       pwm_l, pwm_r, dir_l, dir_r, settled;

  int   checks = 0;
  int   errors = 0;
  int   hl, hr;
  logic s0, s1, dl0, dl_end, dr_end;
  logic pdl = 1'b1, ppl = 1'b0;
  bit   glitch = 1'b0;

  motor_drive u_dut (
    .clk(clk), .rst(rst), .dir(dir),
    .pwm_l(pwm_l), .pwm_r(pwm_r), .dir_l(dir_l), .dir_r(dir_r), .settled(settled)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Called at the negedge of a count==0 cycle; returns at the next one.
  task automatic run_period(input int mid_at = -1, input logic [3:0] mid_dir = 4'b0000);
    hl = 0;
    hr = 0;
    for (int i = 0; i < PER; i++) begin
      if (pwm_l) hl++;
      if (pwm_r) hr++;
      if (dir_l != pdl && (pwm_l || ppl)) glitch = 1'b1;
      pdl = dir_l;
      ppl = pwm_l;
      if (i == 0) begin s0 = settled; dl0 = dir_l; end
      if (i == 1) s1 = settled;
      if (i == PER - 1) begin dl_end = dir_l; dr_end = dir_r; end
      if (i == mid_at) dir = mid_dir;
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    dir = 4'b0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_pwm_l", pwm_l, 0);
    chk("rst_pwm_r", pwm_r, 0);
    chk("rst_dir_l", dir_l, 1);
    chk("rst_dir_r", dir_r, 1);
    chk("rst_settled", settled, 0);

    // Ramp up to full speed
    run_period();
    chk("p0_hl", hl, 0);
    for (int k = 1; k <= 9; k++) begin
      run_period();
      chk("up_hl", hl, 100 * k);
      chk("up_hr", hr, 100 * k);
    end
    run_period();
    chk("full_hl", hl, 1000);
    chk("full_hr", hr, 1000);
    chk("full_s0", s0, 0);
    chk("full_s1", s1, 1);

    // Veer left
    dir = 4'b0101;
    run_period();
    chk("veer0_hl", hl, 1000);
    for (int k = 1; k <= 5; k++) begin
      run_period();
      chk("veer_hl", hl, 1000 - 100 * k);
      chk("veer_hr", hr, 1000);
      chk("veer_dl", dl_end, 1);
      chk("veer_dr", dr_end, 1);
    end

    // Command change mid-period leaves the current width alone
    run_period(500, 4'b0000);
    chk("mid_hl", hl, 500);
    chk("mid_hr", hr, 1000);
    run_period();
    chk("back_hl", hl, 600);
    repeat (3) run_period();
    run_period();
    chk("back_full_hl", hl, 1000);
    chk("back_full_s1", s1, 1);

    // Pivot requested, then reverted while DEAD
    dir = 4'b0111;
    run_period();
    chk("rv_p0_hl", hl, 1000);
    run_period();
    chk("rv_dead1_hl", hl, 0);
    chk("rv_dead1_hr", hr, 900);
    dir = 4'b0000;
    run_period();
    chk("rv_dead2_hl", hl, 0);
    chk("rv_dead2_hr", hr, 800);
    run_period();
    chk("rv_run0_hl", hl, 0);
    chk("rv_run0_dl", dl0, 1);
    chk("rv_run0_hr", hr, 900);
    run_period();
    chk("rv_ramp_hl", hl, 100);
    chk("rv_ramp_hr", hr, 1000);
    repeat (8) run_period();
    run_period();
    chk("rv_full_hl", hl, 1000);
    chk("rv_full_s1", s1, 1);
    chk("rv_dl", dl_end, 1);

    // Ninety-degree left pivot from full
    glitch = 1'b0;
    dir = 4'b0111;
    run_period();
    chk("pv_p0_hl", hl, 1000);
    run_period();
    chk("pv_dead1_hl", hl, 0);
    chk("pv_dead1_hr", hr, 900);
    chk("pv_dead1_dl", dl_end, 1);
    run_period();
    chk("pv_dead2_hl", hl, 0);
    chk("pv_dead2_hr", hr, 800);
    chk("pv_dead2_dl", dl_end, 1);
    run_period();
    chk("pv_run0_hl", hl, 0);
    chk("pv_run0_hr", hr, 700);
    chk("pv_run0_dl", dl0, 0);
    for (int k = 1; k <= 6; k++) begin
      run_period();
      chk("pv_hl", hl, 100 * k);
      chk("pv_hr", hr, 600);
    end
    chk("pv_s1", s1, 1);
    chk("pv_dl", dl_end, 0);
    chk("pv_dr", dr_end, 1);
    chk("pv_glitch", glitch, 0);

    // Stop: ramp both down, polarity held
    dir = 4'b1111;
    run_period();
    chk("stop0_hl", hl, 600);
    for (int k = 1; k <= 6; k++) begin
      run_period();
      chk("stop_hl", hl, 600 - 100 * k);
      chk("stop_hr", hr, 600 - 100 * k);
      chk("stop_dl", dl_end, 0);
      chk("stop_dr", dr_end, 1);
    end
    chk("stop_s1", s1, 1);

    // Reset while left channel is DEAD
    dir = 4'b0000;
    run_period();
    chk("pre_rst_hl", hl, 0);
    repeat (300) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mr_pwm_l", pwm_l, 0);
    chk("mr_pwm_r", pwm_r, 0);
    chk("mr_dir_l", dir_l, 1);
    chk("mr_dir_r", dir_r, 1);
    chk("mr_settled", settled, 0);
    run_period();
    chk("mr_p0_hl", hl, 0);
    run_period();
    chk("mr_p1_hl", hl, 100);
    chk("mr_p1_hr", hr, 100);
    chk("mr_p1_dl", dl_end, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
